display_file_fetcher: RTL

- Parametrised display-file fetch unit for one video plane.
- Issues burst reads starting at the video start register (VSR) and buffers the returned words in a FIFO.
- Unpacks each word into pixels for one of three pixel modes: 4 bpp, 8 bpp or 16 bpp.
- Sits between the memory arbiter burst port and the plane's pixel decoder (CLUT/RGB path); the output behaves as a pixelstream source.

---
 rtl/display_pkg.sv | 49 ++++
 rtl/display_file_fetcher_if.sv | 31 +++
 rtl/display_word_fifo.sv | 62 ++++++
 rtl/display_file_fetcher.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared types for the display-file fetch unit.
// Pixel modes, fetch states and small unpacking helpers.
package display_pkg;

   typedef enum logic [1:0] {
      PM_8BPP  = 2'd0,
      PM_4BPP  = 2'd1,
      PM_16BPP = 2'd2
   } pix_mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_REQ  = 1'b1
   } fetch_state_e;

   function automatic logic [2:0] pixels_per_word(input pix_mode_e m);
      logic [2:0] n;
      unique case (m)
         PM_4BPP:  n = 3'd4;
         PM_16BPP: n = 3'd1;
         default:  n = 3'd2;
      endcase
      return n;
   endfunction

   // Encoding 3 is reserved and behaves as 8 bpp
   function automatic pix_mode_e decode_mode(input logic [1:0] m);
      pix_mode_e pm;
      unique case (m)
         2'd1:    pm = PM_4BPP;
         2'd2:    pm = PM_16BPP;
         default: pm = PM_8BPP;
      endcase
      return pm;
   endfunction

   // An odd byte start skips the leading byte (8 bpp) or two nibbles (4 bpp)
   function automatic logic [1:0] first_sub(input pix_mode_e m,
                                            input logic odd);
      logic [1:0] s;
      unique case (m)
         PM_4BPP:  s = {odd, 1'b0};
         PM_16BPP: s = 2'd0;
         default:  s = {1'b0, odd};
      endcase
      return s;
   endfunction

endpackage

// File: rtl/display_file_fetcher_if.sv
// display_file_fetcher_if: burst port towards the arbiter plus
// the pixelstream port towards the plane's pixel decoder.
interface display_file_fetcher_if #(
   parameter int ADDR_W = 22
);
   logic [ADDR_W-1:0] address;
   logic              as;
   logic              bus_ack;
   logic              burstdata_valid;
   logic [15:0]       din;
   logic              reload_vsr;
   logic [ADDR_W-1:0] vsr_in;
   logic [1:0]        mode;
   logic              read_pixels;
   logic              pix_valid;
   logic              pix_strobe;
   logic [15:0]       pix_data;
   logic              overflow_err;

   modport master (
      output address, as, pix_valid, pix_data, overflow_err,
      input  bus_ack, burstdata_valid, din, reload_vsr,
      input  vsr_in, mode, read_pixels, pix_strobe
   );

   modport slave (
      input  address, as, pix_valid, pix_data, overflow_err,
      output bus_ack, burstdata_valid, din, reload_vsr,
      output vsr_in, mode, read_pixels, pix_strobe
   );
endinterface

// File: rtl/display_word_fifo.sv
// display_word_fifo: DEPTH x 16 word FIFO with a registered head read.
// o_hazard marks a head word written in the same cycle it was read.
module display_word_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       i_flush,
   input  logic                       i_we,
   input  logic [15:0]                i_wd,
   input  logic                       i_re,
   output logic [15:0]                o_q,
   output logic [$clog2(DEPTH):0]     o_cnt,
   output logic                       o_hazard
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [15:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_cnt;
   logic [15:0]   r_q;
   logic          r_hazard;
   logic [AW-1:0] w_rp_nxt;
   logic          w_we;

   assign w_we     = i_we && !i_flush;
   assign w_rp_nxt = r_rp + AW'(i_re);

   // Word storage, no reset needed
   always_ff @(posedge clk) begin
      if (w_we)
         r_mem[r_wp] <= i_wd;
   end

   // Registered head read; sees the old RAM contents on a same-cycle write
   always_ff @(posedge clk) begin
      r_q <= r_mem[w_rp_nxt];
   end

   // Pointers, occupancy and the stale-head flag
   always_ff @(posedge clk) begin
      if (!reset_n || i_flush) begin
         r_wp     <= '0;
         r_rp     <= '0;
         r_cnt    <= '0;
         r_hazard <= 1'b0;
      end else begin
         if (w_we)
            r_wp <= r_wp + AW'(1);
         r_rp     <= w_rp_nxt;
         r_cnt    <= r_cnt + CW'(w_we) - CW'(i_re);
         r_hazard <= w_we && (r_wp == w_rp_nxt);
      end
   end

   assign o_q      = r_q;
   assign o_cnt    = r_cnt;
   assign o_hazard = r_hazard;

endmodule

// File: rtl/display_file_fetcher.sv
// display_file_fetcher: burst fetch FSM, wrap discard and pixel
// unpacker for one video plane, fed through a small word FIFO.
module display_file_fetcher
   import display_pkg::*;
#(
   parameter int ADDR_W      = 22,
   parameter int BURST_WORDS = 4,
   parameter int FIFO_DEPTH  = 8,
   parameter int UNIT_INDEX  = 0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   display_file_fetcher_if.master bus
);
   localparam int OFF_W  = $clog2(BURST_WORDS);
   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int BEAT_W = OFF_W + 2;

   fetch_state_e      r_state;
   logic              r_as;
   logic [ADDR_W-1:0] r_vsr;
   pix_mode_e         r_mode;
   logic [1:0]        r_sub;
   logic [BEAT_W-1:0] r_beat;
   logic              r_discard;
   logic              r_ovf;

   logic [CNT_W-1:0]  w_cnt;
   logic [15:0]       w_q;
   logic              w_hazard;
   logic              w_pix_valid;
   logic              w_wrap;
   logic              w_take;
   logic              w_full;
   logic              w_push;
   logic              w_drop;
   logic [2:0]        w_ppw;
   logic              w_fire;
   logic              w_last;
   logic              w_pop;
   logic              w_start;
   logic [15:0]       w_sh;
   logic [15:0]       w_pix;
   pix_mode_e         w_new_mode;

   display_word_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_flush  (bus.reload_vsr),
      .i_we     (w_push),
      .i_wd     (bus.din),
      .i_re     (w_pop),
      .o_q      (w_q),
      .o_cnt    (w_cnt),
      .o_hazard (w_hazard)
   );

   assign w_pix_valid = (w_cnt != '0) && !w_hazard;
   assign w_full      = (w_cnt == CNT_W'(FIFO_DEPTH));
   assign w_wrap      = (r_beat != '0) && (r_vsr[OFF_W:1] == '0);
   assign w_take      = bus.burstdata_valid && !bus.reload_vsr
                        && !r_discard && !w_wrap;
   assign w_push      = w_take && !w_full;
   assign w_drop      = w_take && w_full;
   assign w_ppw       = pixels_per_word(r_mode);
   assign w_fire      = bus.pix_strobe && w_pix_valid && !bus.reload_vsr;
   assign w_last      = ({1'b0, r_sub} == (w_ppw - 3'd1));
   assign w_pop       = w_fire && w_last;
   assign w_start     = (r_state == ST_IDLE) && bus.read_pixels
                        && ((CNT_W'(FIFO_DEPTH) - w_cnt)
                            >= CNT_W'(BURST_WORDS));
   assign w_new_mode  = decode_mode(bus.mode);
   assign w_sh        = w_q >> {~r_sub, 2'b00};

   // Select the current sub-pixel from the head word, zero-extended
   always_comb begin
      w_pix = 16'h0000;
      unique case (r_mode)
         PM_16BPP: w_pix = w_q;
         PM_4BPP:  w_pix = {12'h000, w_sh[3:0]};
         default:  w_pix = {8'h00, r_sub[0] ? w_q[7:0] : w_q[15:8]};
      endcase
   end

   // Fetch FSM, address advance, beat tracking and sub-pixel index
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state   <= ST_IDLE;
         r_as      <= 1'b0;
         r_vsr     <= '0;
         r_mode    <= PM_8BPP;
         r_sub     <= 2'd0;
         r_beat    <= '0;
         r_discard <= 1'b0;
         r_ovf     <= 1'b0;
      end else if (bus.reload_vsr) begin
         r_state   <= ST_IDLE;
         r_as      <= 1'b0;
         r_mode    <= w_new_mode;
         r_sub     <= first_sub(w_new_mode, bus.vsr_in[0]);
         r_beat    <= '0;
         r_discard <= 1'b1;
         if (w_new_mode == PM_16BPP)
            r_vsr <= {bus.vsr_in[ADDR_W-1:1], 1'b0};
         else
            r_vsr <= bus.vsr_in;
      end else begin
         unique case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state   <= ST_REQ;
                  r_as      <= 1'b1;
                  r_discard <= 1'b0;
               end
            end
            default: begin
               if (bus.bus_ack) begin
                  r_state <= ST_IDLE;
                  r_as    <= 1'b0;
               end
            end
         endcase
         if (w_start)
            r_beat <= '0;
         else if (bus.burstdata_valid && (r_beat != '1))
            r_beat <= r_beat + BEAT_W'(1);
         if (w_push)
            r_vsr <= r_vsr + ADDR_W'(2);
         if (w_drop)
            r_ovf <= 1'b1;
         if (w_fire)
            r_sub <= w_last ? 2'd0 : r_sub + 2'd1;
      end
   end

   a_no_drop : assert property (
      @(posedge clk) disable iff (!reset_n) !w_drop
   ) else $warning("display_file_fetcher[%0d]: beat dropped, FIFO full",
                   UNIT_INDEX);

   assign bus.address      = r_vsr;
   assign bus.as           = r_as;
   assign bus.pix_valid    = w_pix_valid;
   assign bus.pix_data     = w_pix;
   assign bus.overflow_err = r_ovf;

endmodule
